// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, start-glitch rejection, framing/overrun flags and a FWFT RX FIFO.
// Optional parity stage is compiled in with `define UART_RX_PARITY_EN (sense set by PARITY_ODD).
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 uart_rx_i,
    input  logic                 rd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 wr_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 parity_err_o
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int MID          = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CNTW         = AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic                 rx_meta, rx_sync;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 brk;
    logic                 mid;
    logic                 stop_samp;
    logic                 par_bad;
    logic                 good;

    logic [FIFO_DEPTH-1:0][DATA_BITS-1:0] mem;
    logic [AW-1:0]        wptr, rptr;
    logic [CNTW-1:0]      count;
    logic                 full, push, pop;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_sync <= rx_meta;
        end
    end

    assign mid       = (cnt == CW'(MID));
    assign stop_samp = (state == S_STOP) && mid;
    assign good      = stop_samp && rx_sync && !par_bad;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            brk         <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            // Counter free-runs one bit period at a time once a start edge is seen
            if (state == S_IDLE || cnt == CW'(CLKS_PER_BIT - 1))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (brk) begin
                        if (rx_sync) brk <= 1'b0;
                    end else if (!rx_sync) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (mid) begin
                        state   <= rx_sync ? S_IDLE : S_DATA;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (mid) begin
                        shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 4'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (mid) state <= S_STOP;
                end
`endif
                S_STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed
                    if (mid) begin
                        state <= S_IDLE;
                        if (!rx_sync) begin
                            frame_err_o <= 1'b1;
                            brk         <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            par_bit      <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            if (state == S_PARITY && mid) par_bit <= rx_sync;
            parity_err_o <= stop_samp && rx_sync && par_bad;
        end
    end

    assign par_bad = par_bit != ((^shreg) ^ PARITY_ODD[0]);
`else
    assign par_bad      = 1'b0;
    // Parameter kept referenced so both builds share one interface
    assign parity_err_o = 1'b0 & PARITY_ODD[0];
`endif

    assign full    = (count == CNTW'(FIFO_DEPTH));
    assign valid_o = (count != '0);
    assign pop     = rd_i && valid_o;
    assign push    = good && (!full || pop);
    assign data_o  = valid_o ? mem[rptr] : '0;

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            wr_o      <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            wr_o      <= push;
            overrun_o <= good && full && !pop;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame table, directed corner cases and a
// randomized run against a frame-level queue model of the receive FIFO.
module tb_uart_rx_fifo;
    localparam int CPB   = 25_000_000 / 115_200;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       valid, wr, fe, ov, pe;

    always #20 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ(25_000_000), .BAUD(115_200), .DATA_BITS(8),
        .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .uart_rx_i(rx), .rd_i(rd),
        .data_o(data), .valid_o(valid), .wr_o(wr), .frame_err_o(fe),
        .overrun_o(ov), .parity_err_o(pe)
    );

    int total = 0;
    int bad = 0;
    int n_wr = 0, n_fe = 0, n_ov = 0, n_pe = 0;
    logic [7:0] popped[$];

    always @(negedge clk) begin
        if (rstn) begin
            if (wr) n_wr++;
            if (fe) n_fe++;
            if (ov) n_ov++;
            if (pe) n_pe++;
            if (valid && rd) popped.push_back(data);
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       stop_v;
        int         exp_wr;
        int         exp_fe;
    } vec_t;

    vec_t tv[7];
    int b_wr, b_fe, b_ov, b_pe, b_pop;

    function automatic vec_t mkv(logic [7:0] d, logic s, int w, int f);
        vec_t v;
        v.d = d; v.stop_v = s; v.exp_wr = w; v.exp_fe = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        cyc(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_out((^d) ^ par_flip);
`else
        if (par_flip) rx = 1'b1;
`endif
        bit_out(stop_v);
        rx = 1'b1;
    endtask

    task automatic snap();
        b_wr = n_wr; b_fe = n_fe; b_ov = n_ov; b_pe = n_pe; b_pop = popped.size();
    endtask

    task automatic pop1();
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
    endtask

    logic [7:0] model_q[$];
    logic [7:0] exp_pop[$];
    int exp_ov, exp_fe, exp_wr;

    initial begin
        tv[0] = mkv(8'd17, 1'b1, 1, 0);
        tv[1] = mkv(8'd29, 1'b1, 1, 0);
        tv[2] = mkv(8'd50, 1'b1, 1, 0);
        tv[3] = mkv(8'd79, 1'b1, 1, 0);
        tv[4] = mkv(8'd0,  1'b1, 1, 0);
        tv[5] = mkv(8'd57, 1'b1, 1, 0);
        tv[6] = mkv(8'h55, 1'b0, 0, 1);

        cyc(3);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_flags", {wr, fe, ov, pe}, 0);
        rstn = 1'b1;
        cyc(5);

        // Back-to-back frames with rd held high, last one with a bad stop bit
        rd = 1'b1;
        foreach (tv[i]) begin
            snap();
            send_frame(tv[i].d, tv[i].stop_v, 1'b0);
            chk($sformatf("tv%0d_wr", i), n_wr - b_wr, tv[i].exp_wr);
            chk($sformatf("tv%0d_fe", i), n_fe - b_fe, tv[i].exp_fe);
            chk($sformatf("tv%0d_npop", i), popped.size() - b_pop, tv[i].exp_wr);
            if (tv[i].exp_wr == 1 && popped.size() > b_pop)
                chk($sformatf("tv%0d_data", i), popped[b_pop], tv[i].d);
        end
        cyc(20);

        // Overrun: fifth frame dropped, first four kept in order
        rd = 1'b0;
        snap();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        chk("ovr_wr", n_wr - b_wr, 4);
        chk("ovr_ov", n_ov - b_ov, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_valid%0d", i), valid, 1);
            chk($sformatf("ovr_pop%0d", i), data, i);
            pop1();
        end
        chk("ovr_empty", valid, 0);

        // Framing error leaves queued data untouched
        send_frame(8'h12, 1'b1, 1'b0);
        snap();
        send_frame(8'h55, 1'b0, 1'b0);
        cyc(10);
        chk("fe_pulse", n_fe - b_fe, 1);
        chk("fe_nowr", n_wr - b_wr, 0);
        chk("fe_head", data, 8'h12);
        pop1();
        chk("fe_empty", valid, 0);

        // Short low glitch on idle line is ignored
        snap();
        rx = 1'b0;
        cyc(50);
        rx = 1'b1;
        cyc(300);
        chk("gl_flags", (n_wr - b_wr) + (n_fe - b_fe) + (n_pe - b_pe), 0);
        send_frame(8'h41, 1'b1, 1'b0);
        chk("gl_data", data, 8'h41);
        pop1();

        // Reset in the middle of a frame discards it
        snap();
        bit_out(1'b0);
        bit_out(1'b0);
        bit_out(1'b1);
        rx = 1'b0;
        cyc(CPB / 2);
        rstn = 1'b0;
        rx = 1'b1;
        cyc(1);
        chk("mrst_valid", valid, 0);
        rstn = 1'b1;
        cyc(2 * CPB);
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("mrst_wr", n_wr - b_wr, 1);
        chk("mrst_data", data, 8'h3C);
        pop1();
        chk("mrst_empty", valid, 0);

        // Break: one framing error, then recovery once the line goes high
        snap();
        rx = 1'b0;
        cyc(25 * CPB);
        chk("brk_fe", n_fe - b_fe, 1);
        chk("brk_wr", n_wr - b_wr, 0);
        rx = 1'b1;
        cyc(2 * CPB);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("brk_data", data, 8'h5A);
        pop1();

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par_good_wr", n_wr - b_wr, 1);
        chk("par_good_pe", n_pe - b_pe, 0);
        pop1();
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        chk("par_bad_pe", n_pe - b_pe, 1);
        chk("par_bad_wr", n_wr - b_wr, 0);
        cyc(10);
`endif

        // Randomized frames against a frame-level FIFO model
        snap();
        exp_ov = 0; exp_fe = 0; exp_wr = 0;
        for (int k = 0; k < 10; k++) begin
            logic       rmode;
            logic       sbad;
            logic [7:0] d;
            int         gap;
            rmode = 1'($urandom_range(0, 1));
            sbad  = ($urandom_range(0, 5) == 0);
            d     = 8'($urandom);
            gap   = $urandom_range(0, 40);
            rd = rmode;
            if (rmode) begin
                while (model_q.size() > 0) exp_pop.push_back(model_q.pop_front());
            end
            if (sbad) begin
                exp_fe++;
            end else if (rmode) begin
                exp_pop.push_back(d);
                exp_wr++;
            end else if (model_q.size() < DEPTH) begin
                model_q.push_back(d);
                exp_wr++;
            end else begin
                exp_ov++;
            end
            send_frame(d, ~sbad, 1'b0);
            cyc(sbad ? gap + 20 : gap);
        end
        rd = 1'b1;
        cyc(10);
        rd = 1'b0;
        while (model_q.size() > 0) exp_pop.push_back(model_q.pop_front());
        chk("rnd_wr", n_wr - b_wr, exp_wr);
        chk("rnd_fe", n_fe - b_fe, exp_fe);
        chk("rnd_ov", n_ov - b_ov, exp_ov);
        chk("rnd_npop", popped.size() - b_pop, exp_pop.size());
        for (int i = 0; i < exp_pop.size(); i++)
            if (b_pop + i < popped.size())
                chk($sformatf("rnd_pop%0d", i), popped[b_pop + i], exp_pop[i]);
        chk("rnd_empty", valid, 0);
        chk("pe_total", n_pe, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
